// File: rtl/sevenseg_arbiter.sv
// Round-robin arbiter sharing one 8-digit seven-segment display between three requesters.
// An owner keeps the display for a minimum dwell while others wait; its data passes through registered.
module sevenseg_arbiter #(
  parameter int unsigned CLOCK_FREQ = 100000000,
  parameter int unsigned DWELL_MS   = 500
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  req,
  input  logic [95:0] req_display,
  input  logic [23:0] req_enable,
  output logic [2:0]  grant,
  output logic [31:0] display,
  output logic [7:0]  digit_enable,
  output logic        busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam int unsigned DWELL_INT    = (CLOCK_FREQ / 1000) * DWELL_MS;
  localparam logic [31:0] DWELL_CYCLES = 32'(DWELL_INT);
  localparam logic [31:0] RELOAD       = (DWELL_CYCLES == 32'd0) ? 32'd0 : DWELL_CYCLES - 32'd1;

  state_t      state;
  logic [1:0]  last_owner;
  logic [31:0] counter;

  logic [1:0]  start;
  logic [2:0]  rot;
  logic [1:0]  offset;
  logic [1:0]  pick;
  logic        pick_valid;
  logic        owner_req;
  logic        rearb;
  logic [1:0]  sel;
  logic [31:0] sel_display;
  logic [7:0]  sel_enable;

  function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Search order begins just after the most recent owner, so that owner is tried last.
  always_comb begin
    start = add_mod3(last_owner, 2'd1);
    case (start)
      2'd1:    rot = {req[0], req[2], req[1]};
      2'd2:    rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase
  end

  always_comb begin
    pick_valid = 1'b1;
    offset     = 2'd0;
    if (rot[0])      offset = 2'd0;
    else if (rot[1]) offset = 2'd1;
    else if (rot[2]) offset = 2'd2;
    else             pick_valid = 1'b0;
    pick = add_mod3(start, offset);
  end

  always_comb begin
    case (last_owner)
      2'd1:    owner_req = req[1];
      2'd2:    owner_req = req[2];
      default: owner_req = req[0];
    endcase
  end

  // A dropped request wins over an expired counter: the owner is then excluded since its req is low.
  always_comb begin
    rearb = (state == IDLE) || !owner_req || (counter == 32'd0);
    sel   = rearb ? pick : last_owner;
  end

  always_comb begin
    case (sel)
      2'd1: begin
        sel_display = req_display[63:32];
        sel_enable  = req_enable[15:8];
      end
      2'd2: begin
        sel_display = req_display[95:64];
        sel_enable  = req_enable[23:16];
      end
      default: begin
        sel_display = req_display[31:0];
        sel_enable  = req_enable[7:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      grant        <= 3'b000;
      busy         <= 1'b0;
      display      <= 32'd0;
      digit_enable <= 8'd0;
      counter      <= 32'd0;
      last_owner   <= 2'd2;
    end else if (rearb) begin
      if (pick_valid) begin
        state        <= HOLD;
        grant        <= 3'b001 << pick;
        busy         <= 1'b1;
        display      <= sel_display;
        digit_enable <= sel_enable;
        counter      <= RELOAD;
        last_owner   <= pick;
      end else begin
        // Display is left frozen so the last content stays visible while blanked.
        state        <= IDLE;
        grant        <= 3'b000;
        busy         <= 1'b0;
        digit_enable <= 8'd0;
      end
    end else begin
      display      <= sel_display;
      digit_enable <= sel_enable;
      if (counter != 32'd0) begin
        counter <= counter - 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_arbiter.sv
// Randomized and directed bench for sevenseg_arbiter against an ownership-count reference model.
module tb_sevenseg_arbiter;

  localparam int DWELL = 4;

  logic        clk;
  logic        resetn;
  logic [2:0]  req;
  logic [95:0] req_display;
  logic [23:0] req_enable;
  logic [2:0]  grant;
  logic [31:0] display;
  logic [7:0]  digit_enable;
  logic        busy;

  int tests_run;
  int tests_failed;

  // Reference model: who owns the display and for how many cycles so far.
  int          m_owner;
  int          m_last;
  int          m_held;
  logic [2:0]  exp_grant;
  logic [31:0] exp_display;
  logic [7:0]  exp_enable;

  sevenseg_arbiter #(
    .CLOCK_FREQ(1000),
    .DWELL_MS  (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
    .req_display (req_display),
    .req_enable  (req_enable),
    .grant       (grant),
    .display     (display),
    .digit_enable(digit_enable),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    m_owner     = -1;
    m_last      = 2;
    m_held      = 0;
    exp_grant   = 3'b000;
    exp_display = 32'd0;
    exp_enable  = 8'd0;
  endtask

  task automatic model_edge();
    bit found;
    int cand;
    int chosen;
    found  = 0;
    chosen = 0;
    if (m_owner >= 0 && req[m_owner] && m_held < DWELL) begin
      m_held = m_held + 1;
    end else begin
      for (int i = 1; i <= 3; i++) begin
        cand = (m_last + i) % 3;
        if (!found && req[cand]) begin
          found  = 1;
          chosen = cand;
        end
      end
      if (found) begin
        m_owner = chosen;
        m_last  = chosen;
        m_held  = 1;
      end else begin
        m_owner = -1;
      end
    end
    if (m_owner >= 0) begin
      exp_grant   = 3'b001 << m_owner;
      exp_display = req_display[32*m_owner +: 32];
      exp_enable  = req_enable[8*m_owner +: 8];
    end else begin
      exp_grant  = 3'b000;
      exp_enable = 8'd0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic randomize_data();
    req_display = {$urandom, $urandom, $urandom};
    req_enable  = 24'($urandom);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req    = 3'b000;
    randomize_data();
    model_reset();
    #23;
    tests_run++;
    if ({grant, busy, display, digit_enable} !== {3'b000, 1'b0, 32'd0, 8'd0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: got grant=%b busy=%b display=%h en=%h, want all zero",
               grant, busy, display, digit_enable);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tick();
    tests_run++;
    if ({grant, busy, digit_enable} !== {3'b000, 1'b0, 8'd0}) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_reset: got grant=%b busy=%b en=%h, want 000/0/00",
               grant, busy, digit_enable);
    end
  endtask

  task automatic test_passthrough();
    req                = 3'b001;
    req_display[31:0]  = 32'h1234_5678;
    req_enable[7:0]    = 8'hFF;
    tick();
    tests_run++;
    if ({grant, busy, display, digit_enable} !== {3'b001, 1'b1, 32'h1234_5678, 8'hFF}) begin
      tests_failed++;
      $display("[TB] FAIL first_grant: got grant=%b busy=%b display=%h en=%h, want 001/1/12345678/ff",
               grant, busy, display, digit_enable);
    end
    req_display[31:0] = 32'hCAFE_0000;
    #2;
    tests_run++;
    if (display !== 32'h1234_5678) begin
      tests_failed++;
      $display("[TB] FAIL registered_latency: display=%h before edge, want 12345678", display);
    end
    tick();
    tests_run++;
    if (display !== 32'hCAFE_0000 || grant !== 3'b001) begin
      tests_failed++;
      $display("[TB] FAIL live_update: got display=%h grant=%b, want cafe0000/001", display, grant);
    end
  endtask

  task automatic test_round_robin();
    int changes;
    req = 3'b111;
    changes = 0;
    for (int c = 0; c < 26; c++) begin
      randomize_data();
      tick();
      tests_run++;
      if ({grant, busy, display, digit_enable} !== {exp_grant, |exp_grant, exp_display, exp_enable}) begin
        tests_failed++;
        $display("[TB] FAIL round_robin c=%0d: got %b/%b/%h/%h, want %b/%b/%h/%h", c,
                 grant, busy, display, digit_enable, exp_grant, |exp_grant, exp_display, exp_enable);
      end
      tests_run++;
      if (grant === 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL rr_no_gap c=%0d: got grant=000, want a one-hot owner", c);
      end
    end
  endtask

  task automatic test_early_drop();
    req = 3'b000;
    tick();
    req = 3'b001;
    tick();
    req = 3'b011;
    tick();
    tick();
    tests_run++;
    if (grant !== 3'b001) begin
      tests_failed++;
      $display("[TB] FAIL early_drop_hold: got grant=%b, want 001", grant);
    end
    req = 3'b010;
    randomize_data();
    tick();
    tests_run++;
    if (grant !== 3'b010 || grant !== exp_grant || display !== exp_display) begin
      tests_failed++;
      $display("[TB] FAIL early_drop_switch: got grant=%b display=%h, want 010/%h",
               grant, display, exp_display);
    end
  endtask

  task automatic test_single_hold();
    req = 3'b100;
    tick();
    for (int c = 0; c < 20; c++) begin
      randomize_data();
      tick();
      tests_run++;
      if (grant !== 3'b100 || busy !== 1'b1 || display !== req_display[95:64]) begin
        tests_failed++;
        $display("[TB] FAIL single_hold c=%0d: got grant=%b busy=%b display=%h, want 100/1/%h",
                 c, grant, busy, display, req_display[95:64]);
      end
    end
  endtask

  task automatic test_release_idle();
    logic [31:0] frozen;
    req                = 3'b010;
    req_display[63:32] = 32'hBEEF_0042;
    req_enable[15:8]   = 8'h3C;
    tick();
    tests_run++;
    if ({grant, display, digit_enable} !== {3'b010, 32'hBEEF_0042, 8'h3C}) begin
      tests_failed++;
      $display("[TB] FAIL owner1_grant: got grant=%b display=%h en=%h, want 010/beef0042/3c",
               grant, display, digit_enable);
    end
    frozen = 32'hBEEF_0042;
    req = 3'b000;
    tick();
    for (int c = 0; c < 3; c++) begin
      tests_run++;
      if ({grant, busy, display, digit_enable} !== {3'b000, 1'b0, frozen, 8'h00}) begin
        tests_failed++;
        $display("[TB] FAIL idle_frozen c=%0d: got %b/%b/%h/%h, want 000/0/%h/00",
                 c, grant, busy, display, digit_enable, frozen);
      end
      randomize_data();
      tick();
    end
  endtask

  task automatic test_async_reset();
    req = 3'b111;
    tick();
    tick();
    #3;
    resetn = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if ({grant, busy, display, digit_enable} !== {3'b000, 1'b0, 32'd0, 8'd0}) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got %b/%b/%h/%h, want all zero",
               grant, busy, display, digit_enable);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    randomize_data();
    tick();
    tests_run++;
    if (grant !== 3'b001 || display !== req_display[31:0] || grant !== exp_grant) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_priority: got grant=%b display=%h, want 001/%h",
               grant, display, req_display[31:0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      end
      randomize_data();
      tick();
      tests_run++;
      if ({grant, busy, display, digit_enable} !== {exp_grant, |exp_grant, exp_display, exp_enable}) begin
        tests_failed++;
        $display("[TB] FAIL random c=%0d req=%b: got %b/%b/%h/%h, want %b/%b/%h/%h", c, req,
                 grant, busy, display, digit_enable, exp_grant, |exp_grant, exp_display, exp_enable);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    resetn       = 1'b0;
    req          = 3'b000;
    req_display  = 96'd0;
    req_enable   = 24'd0;
    model_reset();
    test_reset();
    test_passthrough();
    test_round_robin();
    test_early_drop();
    test_single_hold();
    test_release_idle();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
